// File: rtl/ypc_multicycle.sv
// ypc_multicycle: multi-cycle RV-style core (addi, add, sub, lui, ebreak).
// Each instruction goes through FETCH -> WAIT -> EXEC. The fetch uses a
// valid/ready request and a separate response-valid strobe. The core halts on
// ebreak or on any unsupported encoding.
// Optional feature: define YPC_INSTRET_EN to add the 64-bit retired-instruction
// counter output port "instret".
module ypc_multicycle #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            retire,
    output logic            halt,
    output logic            illegal,
`ifdef YPC_INSTRET_EN
    output logic [63:0]     instret,
`endif
    output logic [XLEN-1:0] ret
);

    localparam int          RAW    = (NREG == 16) ? 4 : 5;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_REG = 7'b0110011;
    localparam logic [6:0]  OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_ir;
    logic [XLEN-1:0]   r_rf [NREG];
    logic              r_retire;
    logic              r_halt;
    logic              r_illegal;
    logic [XLEN-1:0]   r_ret;

    logic [6:0]        w_op;
    logic [4:0]        w_rd;
    logic [2:0]        w_f3;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [6:0]        w_f7;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_wb_val;
    logic              w_legal;
    logic              w_is_ebreak;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_use_rd;
    logic              w_idx_bad;
    logic              w_exec_ok;
    logic              w_retire_now;
    logic              w_wr_en;

    assign w_op  = r_ir[6:0];
    assign w_rd  = r_ir[11:7];
    assign w_f3  = r_ir[14:12];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];
    assign w_f7  = r_ir[31:25];

    // Immediates are sign-extended to the full datapath width.
    assign w_imm_i = XLEN'($signed(r_ir[31:20]));
    assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'h000}));

    // Combinational read ports; x0 always reads as zero.
    assign w_rs1_val = (w_rs1 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs1[RAW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0) ? {XLEN{1'b0}} : r_rf[w_rs2[RAW-1:0]];

    // Decode the latched instruction and compute its write-back value.
    always_comb begin
        w_legal     = 1'b0;
        w_is_ebreak = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_use_rd    = 1'b0;
        w_wb_val    = {XLEN{1'b0}};
        if (r_ir == EBREAK) begin
            w_is_ebreak = 1'b1;
        end else begin
            case (w_op)
                OP_IMM: begin
                    if (w_f3 == 3'b000) begin
                        w_legal   = 1'b1;
                        w_use_rs1 = 1'b1;
                        w_use_rd  = 1'b1;
                        w_wb_val  = w_rs1_val + w_imm_i;
                    end else begin
                        w_legal = 1'b0;
                    end
                end
                OP_REG: begin
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_use_rd  = 1'b1;
                    if ((w_f3 == 3'b000) && (w_f7 == 7'b0000000)) begin
                        w_legal  = 1'b1;
                        w_wb_val = w_rs1_val + w_rs2_val;
                    end else if ((w_f3 == 3'b000) && (w_f7 == 7'b0100000)) begin
                        w_legal  = 1'b1;
                        w_wb_val = w_rs1_val - w_rs2_val;
                    end else begin
                        w_legal = 1'b0;
                    end
                end
                OP_LUI: begin
                    w_legal  = 1'b1;
                    w_use_rd = 1'b1;
                    w_wb_val = w_imm_u;
                end
                default: begin
                    w_legal = 1'b0;
                end
            endcase
        end
    end

    // With a 16-entry register file any referenced index above x15 is unsupported.
    assign w_idx_bad = (NREG == 16) &&
                       ((w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]) || (w_use_rd && w_rd[4]));
    assign w_exec_ok    = w_legal && !w_idx_bad;
    assign w_retire_now = (r_state == S_EXEC) && (w_is_ebreak || w_exec_ok);
    assign w_wr_en      = (r_state == S_EXEC) && w_exec_ok && (w_rd != 5'd0);

    // Next-state logic of the fetch/execute sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH: begin
                if (imem_req_ready) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_EXEC: begin
                if (w_is_ebreak || !w_exec_ok) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_HALT;
            end
        endcase
    end

    // State register; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC, instruction register and the status/retire outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0000_0000;
            r_retire  <= 1'b0;
            r_halt    <= 1'b0;
            r_illegal <= 1'b0;
            r_ret     <= {XLEN{1'b0}};
        end else begin
            r_retire <= w_retire_now;
            if ((r_state == S_WAIT) && imem_rsp_valid) begin
                r_ir <= imem_rsp_data;
            end
            if ((r_state == S_EXEC) && w_exec_ok && !w_is_ebreak) begin
                r_pc <= r_pc + XLEN'(3'd4);
            end
            if ((r_state == S_EXEC) && (w_is_ebreak || !w_exec_ok)) begin
                r_halt <= 1'b1;
            end
            if ((r_state == S_EXEC) && !w_is_ebreak && !w_exec_ok) begin
                r_illegal <= 1'b1;
            end
            if (w_wr_en) begin
                r_ret <= w_wb_val;
            end
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= {XLEN{1'b0}};
            end
        end else if (w_wr_en) begin
            r_rf[w_rd[RAW-1:0]] <= w_wb_val;
        end
    end

`ifdef YPC_INSTRET_EN
    logic [63:0] r_instret;

    // Count every retired instruction, ebreak included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= 64'd0;
        end else if (w_retire_now) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

    // The request is dropped while reset is held so nothing is issued in that cycle.
    assign imem_req_valid = (r_state == S_FETCH) && !reset;
    assign imem_addr      = r_pc;
    assign retire         = r_retire;
    assign halt           = r_halt;
    assign illegal        = r_illegal;
    assign ret            = r_ret;

endmodule

// File: tb/tb_ypc_multicycle.sv
// Bench for ypc_multicycle: two instances (XLEN=32/NREG=32 at PC 0 and
// XLEN=64/NREG=16 at PC 0x1000) run the same programs against a
// behavioural instruction-level reference model.
module tb_ypc_multicycle;

    localparam logic [63:0] BASE_A = 64'h0;
    localparam logic [63:0] BASE_B = 64'h1000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic        clk;
    logic        reset;
    logic        a_req_valid, a_req_ready, a_rsp_valid, a_retire, a_halt, a_illegal;
    logic [31:0] a_addr, a_rsp_data, a_ret;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_retire, b_halt, b_illegal;
    logic [63:0] b_addr, b_ret;
    logic [31:0] b_rsp_data;
`ifdef YPC_INSTRET_EN
    logic [63:0] a_instret, b_instret;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] prog [0:63];
    int          plen;

    // reference-model expectations
    logic [63:0] exp_ret  [2][0:255];
    int          exp_nret [2];
    logic [63:0] exp_addr [2][0:255];
    int          exp_naddr[2];
    logic        exp_ill  [2];

    // observations
    logic [63:0] obs_ret  [2][0:255];
    int          obs_nret [2];
    logic [63:0] obs_addr [2][0:255];
    int          obs_naddr[2];
    int          obs_halt_cyc[2];
    int          obs_unstable[2];
    int          obs_req_after_halt[2];
    logic        obs_ill  [2];
    logic        obs_halt [2];

    ypc_multicycle #(.XLEN(32), .NREG(32), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_addr(a_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
        .retire(a_retire), .halt(a_halt), .illegal(a_illegal),
`ifdef YPC_INSTRET_EN
        .instret(a_instret),
`endif
        .ret(a_ret)
    );

    ypc_multicycle #(.XLEN(64), .NREG(16), .RESET_PC(BASE_B)) dut_b (
        .clk(clk), .reset(reset),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .retire(b_retire), .halt(b_halt), .illegal(b_illegal),
`ifdef YPC_INSTRET_EN
        .instret(b_instret),
`endif
        .ret(b_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
        return {f7, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lui(input int rd, input logic [19:0] imm);
        return {imm, rd[4:0], 7'b0110111};
    endfunction

    function automatic logic [31:0] fetch(input int k, input logic [63:0] a);
        logic [63:0] off;
        off = a - ((k == 0) ? BASE_A : BASE_B);
        if ((off[1:0] != 2'b00) || ((off >> 2) >= 64'(plen))) return 32'h0;
        return prog[off[7:2]];
    endfunction

    // Instruction-level reference: executes the program with plain arithmetic.
    task automatic model_run(input int k, input int xlen, input int nreg, input logic [63:0] base);
        logic [63:0] regs [0:31];
        logic [63:0] mask, pc, rv, val, idx;
        logic [31:0] ins;
        int rd, rs1, rs2;
        bit ok, hi;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 32; i++) regs[i] = 64'h0;
        pc = base; rv = 64'h0;
        exp_nret[k] = 0; exp_naddr[k] = 0; exp_ill[k] = 1'b0;
        for (int s = 0; s < 200; s++) begin
            exp_addr[k][exp_naddr[k]] = pc; exp_naddr[k]++;
            idx = (pc - base) >> 2;
            ins = (idx < 64'(plen)) ? prog[idx[5:0]] : 32'h0;
            rd = int'(ins[11:7]); rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
            if (ins == EBRK) begin
                exp_ret[k][exp_nret[k]] = rv; exp_nret[k]++;
                break;
            end
            ok = 1'b0; hi = 1'b0; val = 64'h0;
            if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
                ok = 1'b1; val = regs[rs1] + {{52{ins[31]}}, ins[31:20]};
                hi = (rs1 >= nreg) || (rd >= nreg);
            end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h00) begin
                ok = 1'b1; val = regs[rs1] + regs[rs2];
                hi = (rs1 >= nreg) || (rs2 >= nreg) || (rd >= nreg);
            end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin
                ok = 1'b1; val = regs[rs1] - regs[rs2];
                hi = (rs1 >= nreg) || (rs2 >= nreg) || (rd >= nreg);
            end else if (ins[6:0] == 7'h37) begin
                ok = 1'b1; val = {{32{ins[31]}}, ins[31:12], 12'h000};
                hi = (rd >= nreg);
            end
            if (!ok || hi) begin
                exp_ill[k] = 1'b1;
                break;
            end
            val = val & mask;
            if (rd != 0) begin
                regs[rd] = val; rv = val;
            end
            exp_ret[k][exp_nret[k]] = rv; exp_nret[k]++;
            pc = (pc + 64'd4) & mask;
        end
    endtask

    task automatic model_both();
        model_run(0, 32, 32, BASE_A);
        model_run(1, 64, 16, BASE_B);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_data = 32'h0;
        b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives both instruction memories cycle by cycle and records what the cores do.
    task automatic run_prog(input bit rnd, input int lr, input int ls);
        int st[2], wc[2], latr[2], lats[2];
        bit first[2];
        logic [63:0] cur[2], ad[2], rv[2];
        logic v[2], rt[2], hl[2], il[2], rdy[2], rsv[2];
        logic [31:0] rdat[2];
        int cyc, post;
        bit done;
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; wc[k] = 0; first[k] = 1'b1; latr[k] = lr; lats[k] = ls; cur[k] = 64'h0;
            obs_nret[k] = 0; obs_naddr[k] = 0; obs_halt_cyc[k] = -1;
            obs_unstable[k] = 0; obs_req_after_halt[k] = 0;
        end
        cyc = 0; post = 0; done = 1'b0;
        while (!done) begin
            #1;
            v[0] = a_req_valid; ad[0] = {32'h0, a_addr}; rt[0] = a_retire; hl[0] = a_halt;
            il[0] = a_illegal; rv[0] = {32'h0, a_ret};
            v[1] = b_req_valid; ad[1] = b_addr; rt[1] = b_retire; hl[1] = b_halt;
            il[1] = b_illegal; rv[1] = b_ret;
            for (int k = 0; k < 2; k++) begin
                obs_ill[k] = il[k]; obs_halt[k] = hl[k];
                if (rt[k] && obs_nret[k] < 256) begin
                    obs_ret[k][obs_nret[k]] = rv[k]; obs_nret[k]++;
                end
                if (hl[k] && obs_halt_cyc[k] < 0) obs_halt_cyc[k] = cyc;
                if (hl[k] && v[k]) obs_req_after_halt[k]++;
                rdy[k] = 1'b0; rsv[k] = 1'b0; rdat[k] = $urandom;
                if (st[k] == 0) begin
                    if (v[k]) begin
                        if (first[k]) begin
                            if (obs_naddr[k] < 256) begin
                                obs_addr[k][obs_naddr[k]] = ad[k]; obs_naddr[k]++;
                            end
                            cur[k] = ad[k]; first[k] = 1'b0;
                        end else if (ad[k] !== cur[k]) begin
                            obs_unstable[k]++;
                        end
                        if (wc[k] >= latr[k]) begin
                            rdy[k] = 1'b1; st[k] = 1; wc[k] = 0;
                        end else begin
                            wc[k]++;
                        end
                    end
                end else begin
                    wc[k]++;
                    if (wc[k] >= lats[k]) begin
                        rsv[k] = 1'b1; rdat[k] = fetch(k, cur[k]);
                        st[k] = 0; wc[k] = 0; first[k] = 1'b1;
                        if (rnd) begin
                            latr[k] = $urandom_range(0, 3); lats[k] = $urandom_range(1, 4);
                        end
                    end
                end
            end
            a_req_ready = rdy[0]; a_rsp_valid = rsv[0]; a_rsp_data = rdat[0];
            b_req_ready = rdy[1]; b_rsp_valid = rsv[1]; b_rsp_data = rdat[1];
            if (hl[0] && hl[1]) post++;
            if (post > 4 || cyc >= 3000) begin
                done = 1'b1;
            end else begin
                @(posedge clk); @(negedge clk); cyc++;
            end
        end
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0;
        total++;
        if (post <= 4) begin
            bad++; $display("FAIL run_timeout: halted a=%0b b=%0b, required both halted", hl[0], hl[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if (a_req_valid !== 1'b0 || b_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_req_valid: got a=%b b=%b, required 0", a_req_valid, b_req_valid);
        end
        total++;
        if ({a_halt, a_illegal, a_retire, b_halt, b_illegal, b_retire} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got a=%b%b%b b=%b%b%b, required 0", a_halt, a_illegal, a_retire, b_halt, b_illegal, b_retire);
        end
        total++;
        if (a_ret !== 32'h0 || b_ret !== 64'h0) begin
            bad++; $display("FAIL reset_ret: got a=%h b=%h, required 0", a_ret, b_ret);
        end
        total++;
        if (a_addr !== BASE_A[31:0] || b_addr !== BASE_B) begin
            bad++; $display("FAIL reset_pc: got a=%h b=%h, required %h %h", a_addr, b_addr, BASE_A[31:0], BASE_B);
        end
`ifdef YPC_INSTRET_EN
        total++;
        if (a_instret !== 64'd0 || b_instret !== 64'd0) begin
            bad++; $display("FAIL reset_instret: got a=%0d b=%0d, required 0", a_instret, b_instret);
        end
`endif
        reset = 1'b0;
        #1;
        total++;
        if (a_req_valid !== 1'b1 || b_req_valid !== 1'b1) begin
            bad++; $display("FAIL reset_fetch: got a=%b b=%b, required 1", a_req_valid, b_req_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        prog[0] = enc_addi(1, 0, 5); prog[1] = enc_addi(2, 1, -3); prog[2] = EBRK; plen = 3;
        model_both(); do_reset(); run_prog(1'b0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_nret[k] !== 3 || obs_nret[k] !== exp_nret[k]) begin
                bad++; $display("FAIL basic_retires dut%0d: got %0d, required 3", k, obs_nret[k]);
            end
            for (int i = 0; i < obs_nret[k] && i < exp_nret[k]; i++) begin
                total++;
                if (obs_ret[k][i] !== exp_ret[k][i]) begin
                    bad++; $display("FAIL basic_ret dut%0d #%0d: got %h, required %h", k, i, obs_ret[k][i], exp_ret[k][i]);
                end
            end
            total++;
            if (obs_ret[k][2] !== 64'd2) begin
                bad++; $display("FAIL basic_final dut%0d: got %h, required 2", k, obs_ret[k][2]);
            end
            total++;
            if (obs_halt_cyc[k] !== 9) begin
                bad++; $display("FAIL basic_halt_cycle dut%0d: got %0d, required 9", k, obs_halt_cyc[k]);
            end
            total++;
            if (obs_ill[k] !== 1'b0 || obs_halt[k] !== 1'b1) begin
                bad++; $display("FAIL basic_status dut%0d: got ill=%b halt=%b, required 0 1", k, obs_ill[k], obs_halt[k]);
            end
            for (int i = 0; i < exp_naddr[k]; i++) begin
                total++;
                if (obs_addr[k][i] !== exp_addr[k][i]) begin
                    bad++; $display("FAIL basic_addr dut%0d #%0d: got %h, required %h", k, i, obs_addr[k][i], exp_addr[k][i]);
                end
            end
        end
`ifdef YPC_INSTRET_EN
        total++;
        if (a_instret !== 64'd3 || b_instret !== 64'd3) begin
            bad++; $display("FAIL basic_instret: got a=%0d b=%0d, required 3", a_instret, b_instret);
        end
`endif
    endtask

    task automatic test_addsub();
        prog[0] = enc_lui(3, 20'h12345); prog[1] = enc_addi(4, 0, 1);
        prog[2] = enc_r(7'h20, 5, 4, 3); prog[3] = enc_r(7'h00, 6, 5, 3); prog[4] = EBRK; plen = 5;
        model_both(); do_reset(); run_prog(1'b0, 0, 1);
        total++;
        if (obs_ret[0][0] !== 64'h1234_5000 || obs_ret[1][0] !== 64'h1234_5000) begin
            bad++; $display("FAIL lui_x3: got a=%h b=%h, required 12345000", obs_ret[0][0], obs_ret[1][0]);
        end
        total++;
        if (obs_ret[0][2] !== 64'hEDCB_B001 || obs_ret[1][2] !== 64'hFFFF_FFFF_EDCB_B001) begin
            bad++; $display("FAIL sub_x5: got a=%h b=%h, required edcbb001 / ffffffffedcbb001", obs_ret[0][2], obs_ret[1][2]);
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_nret[k] !== exp_nret[k]) begin
                bad++; $display("FAIL addsub_retires dut%0d: got %0d, required %0d", k, obs_nret[k], exp_nret[k]);
            end
            for (int i = 0; i < obs_nret[k] && i < exp_nret[k]; i++) begin
                total++;
                if (obs_ret[k][i] !== exp_ret[k][i]) begin
                    bad++; $display("FAIL addsub_ret dut%0d #%0d: got %h, required %h", k, i, obs_ret[k][i], exp_ret[k][i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        prog[0] = enc_addi(1, 0, 5); prog[1] = enc_addi(2, 1, -3); prog[2] = EBRK; plen = 3;
        model_both(); do_reset(); run_prog(1'b0, 4, 4);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_unstable[k] !== 0) begin
                bad++; $display("FAIL bp_addr_stable dut%0d: got %0d changes, required 0", k, obs_unstable[k]);
            end
            total++;
            if (obs_nret[k] !== exp_nret[k] || obs_ret[k][obs_nret[k] > 0 ? obs_nret[k]-1 : 0] !== 64'd2) begin
                bad++; $display("FAIL bp_result dut%0d: got %0d retires, required %0d ending in 2", k, obs_nret[k], exp_nret[k]);
            end
            total++;
            if (obs_halt_cyc[k] !== 9 + 3 * 7) begin
                bad++; $display("FAIL bp_halt_cycle dut%0d: got %0d, required %0d", k, obs_halt_cyc[k], 9 + 3 * 7);
            end
        end
    endtask

    task automatic test_illegal();
        prog[0] = enc_addi(1, 0, 9); prog[1] = enc_addi(0, 0, 7); prog[2] = 32'h0; plen = 3;
        model_both(); do_reset(); run_prog(1'b0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_nret[k] !== 2 || obs_ret[k][1] !== 64'd9) begin
                bad++; $display("FAIL x0_write dut%0d: got %0d retires ret=%h, required 2 and 9", k, obs_nret[k], obs_ret[k][1]);
            end
            total++;
            if (obs_ill[k] !== 1'b1 || obs_halt[k] !== 1'b1 || exp_ill[k] !== 1'b1) begin
                bad++; $display("FAIL illegal_flag dut%0d: got ill=%b halt=%b, required 1 1", k, obs_ill[k], obs_halt[k]);
            end
            total++;
            if (obs_req_after_halt[k] !== 0) begin
                bad++; $display("FAIL req_after_halt dut%0d: got %0d, required 0", k, obs_req_after_halt[k]);
            end
        end
`ifdef YPC_INSTRET_EN
        total++;
        if (a_instret !== 64'd2 || b_instret !== 64'd2) begin
            bad++; $display("FAIL illegal_instret: got a=%0d b=%0d, required 2", a_instret, b_instret);
        end
`endif
    endtask

    task automatic test_nreg16();
        prog[0] = enc_addi(17, 0, 1); prog[1] = EBRK; plen = 2;
        do_reset(); run_prog(1'b0, 0, 1);
        total++;
        if (obs_ill[0] !== 1'b0 || obs_nret[0] !== 2 || obs_ret[0][0] !== 64'd1) begin
            bad++; $display("FAIL nreg32_x17: got ill=%b retires=%0d, required 0 2", obs_ill[0], obs_nret[0]);
        end
        total++;
        if (obs_ill[1] !== 1'b1 || obs_nret[1] !== 0) begin
            bad++; $display("FAIL nreg16_x17: got ill=%b retires=%0d, required 1 0", obs_ill[1], obs_nret[1]);
        end
    endtask

    task automatic test_wrap();
        prog[0] = enc_addi(1, 0, -1); prog[1] = enc_addi(1, 1, 1);
        prog[2] = enc_lui(2, 20'h80000); prog[3] = EBRK; plen = 4;
        model_both(); do_reset(); run_prog(1'b0, 0, 1);
        total++;
        if (obs_ret[0][0] !== 64'hFFFF_FFFF || obs_ret[1][0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL wrap_minus1: got a=%h b=%h", obs_ret[0][0], obs_ret[1][0]);
        end
        total++;
        if (obs_ret[0][1] !== 64'h0 || obs_ret[1][1] !== 64'h0) begin
            bad++; $display("FAIL wrap_zero: got a=%h b=%h, required 0", obs_ret[0][1], obs_ret[1][1]);
        end
        total++;
        if (obs_ret[0][2] !== 64'h8000_0000 || obs_ret[1][2] !== 64'hFFFF_FFFF_8000_0000) begin
            bad++; $display("FAIL wrap_lui: got a=%h b=%h, required 80000000 / ffffffff80000000", obs_ret[0][2], obs_ret[1][2]);
        end
        total++;
        if (obs_nret[0] !== exp_nret[0] || obs_nret[1] !== exp_nret[1]) begin
            bad++; $display("FAIL wrap_retires: got %0d %0d, required %0d %0d", obs_nret[0], obs_nret[1], exp_nret[0], exp_nret[1]);
        end
    endtask

    task automatic test_reset_midflight();
        prog[0] = enc_addi(1, 0, 5); prog[1] = enc_addi(2, 1, -3); prog[2] = EBRK; plen = 3;
        model_both(); do_reset();
        a_req_ready = 1'b1; b_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        a_req_ready = 1'b0; b_req_ready = 1'b0; reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        a_rsp_valid = 1'b1; a_rsp_data = 32'h0; b_rsp_valid = 1'b1; b_rsp_data = 32'h0;
        @(posedge clk); @(negedge clk);
        a_rsp_valid = 1'b0; b_rsp_valid = 1'b0;
        run_prog(1'b0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs_addr[k][0] !== exp_addr[k][0]) begin
                bad++; $display("FAIL midreset_refetch dut%0d: got %h, required %h", k, obs_addr[k][0], exp_addr[k][0]);
            end
            total++;
            if (obs_ill[k] !== 1'b0 || obs_nret[k] !== 3 || obs_ret[k][2] !== 64'd2) begin
                bad++; $display("FAIL midreset_stale dut%0d: got ill=%b retires=%0d, required 0 3", k, obs_ill[k], obs_nret[k]);
            end
        end
`ifdef YPC_INSTRET_EN
        total++;
        if (a_instret !== 64'd3 || b_instret !== 64'd3) begin
            bad++; $display("FAIL midreset_instret: got a=%0d b=%0d, required 3", a_instret, b_instret);
        end
`endif
    endtask

    function automatic int rreg();
        return ($urandom_range(0, 25) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            plen = int'($urandom_range(6, 20));
            for (int i = 0; i < plen - 1; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: prog[i] = enc_addi(rreg(), rreg(), int'($urandom_range(0, 4095)));
                    3, 4:    prog[i] = enc_r(7'h00, rreg(), rreg(), rreg());
                    5, 6:    prog[i] = enc_r(7'h20, rreg(), rreg(), rreg());
                    7, 8:    prog[i] = enc_lui(rreg(), 20'($urandom));
                    default: prog[i] = ($urandom_range(0, 3) == 0) ? enc_r(7'h01, 1, 2, 3)
                                                                   : enc_addi(rreg(), rreg(), -7);
                endcase
            end
            prog[plen-1] = EBRK;
            model_both(); do_reset(); run_prog(1'b1, 1, 2);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs_nret[k] !== exp_nret[k] || obs_ill[k] !== exp_ill[k]) begin
                    bad++; $display("FAIL rand%0d_status dut%0d: got %0d/%b, required %0d/%b", it, k, obs_nret[k], obs_ill[k], exp_nret[k], exp_ill[k]);
                end
                for (int i = 0; i < obs_nret[k] && i < exp_nret[k]; i++) begin
                    total++;
                    if (obs_ret[k][i] !== exp_ret[k][i]) begin
                        bad++; $display("FAIL rand%0d_ret dut%0d #%0d: got %h, required %h", it, k, i, obs_ret[k][i], exp_ret[k][i]);
                    end
                end
                for (int i = 0; i < obs_naddr[k] && i < exp_naddr[k]; i++) begin
                    total++;
                    if (obs_addr[k][i] !== exp_addr[k][i]) begin
                        bad++; $display("FAIL rand%0d_addr dut%0d #%0d: got %h, required %h", it, k, i, obs_addr[k][i], exp_addr[k][i]);
                    end
                end
                total++;
                if (obs_unstable[k] !== 0 || obs_req_after_halt[k] !== 0) begin
                    bad++; $display("FAIL rand%0d_handshake dut%0d: unstable=%0d after_halt=%0d, required 0", it, k, obs_unstable[k], obs_req_after_halt[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_data = 32'h0;
        b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = 32'h0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        plen = 0;
        test_reset();
        test_basic();
        test_addsub();
        test_backpressure();
        test_illegal();
        test_reset();
        test_nreg16();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
